// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding imem read and a
// one-entry valid/ready output register. Taken-branch redirects retarget the
// PC and squash any wrong-path instruction in flight or buffered.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        req_fire;
  logic        out_hs;
  logic        resp_drop;

  // Outputs decode only from registered state and the downstream ready.
  always_comb begin
    imem_req_valid = (state_q == FETCH) && (!instr_valid_q || instr_ready);
    imem_addr      = pc_q;
    instr_valid    = instr_valid_q;
    instr          = instr_q;
    instr_pc       = instr_pc_q;
    instr_pc_plus4 = instr_pc_q + 32'd4;
  end

  // Next-state logic; the redirect block at the end overrides everything else.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    resp_drop     = 1'b0;
    req_fire      = imem_req_valid && imem_req_ready;
    out_hs        = instr_valid_q && instr_ready;

    if (out_hs) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
          // A request accepted alongside a redirect is already wrong-path.
          if (redirect) begin
            discard_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_d   = FETCH;
          discard_d = 1'b0;
          if (discard_q || redirect) begin
            resp_drop = 1'b1;
          end else begin
            instr_d       = imem_resp_data;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
            pc_d          = req_pc_q + 32'd4;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      pc_d          = redirect_target & 32'hFFFF_FFFC;
      instr_valid_d = 1'b0;
    end
  end

  // Fetch control and output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'd0;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // A consumed instruction counts only if no redirect cancels it; a dropped
  // response and a squashed output register in one cycle count once.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (out_hs && !redirect) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (resp_drop || (redirect && instr_valid_q)) begin
      perf_flushed_d = perf_flushed_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_flushed_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
